// File: rtl/harmonic_accumulator.sv
// harmonic_accumulator: sequences the harmonic series for one output sample,
// fetching a sine value per harmonic, weighting it by the attenuation multiple
// and accumulating; emits the scaled sum as one registered sample.
module harmonic_accumulator #(
  parameter int DIV_BIT     = 8,
  parameter int SAMPLE_BITS = 16,
  parameter int HARM_BITS   = 7
) (
  input  logic                             i_Clock,
  input  logic                             i_Reset,
  input  logic                             i_Sample_Start,
  input  logic [HARM_BITS-1:0]             i_Harmonic_Count,
  input  logic [DIV_BIT-1:0]               i_Mult,
  input  logic [SAMPLE_BITS-1:0]           i_Sine,
  input  logic                             i_Sine_Valid,
  output logic                             o_Mult_Restart,
  output logic                             o_Mult_Start,
  output logic                             o_Sine_Req,
  output logic [HARM_BITS-1:0]             o_Harmonic,
  output logic                             o_Busy,
  output logic [SAMPLE_BITS+HARM_BITS-1:0] o_Sample,
  output logic                             o_Sample_Valid
);

  localparam int ACC_W  = SAMPLE_BITS + DIV_BIT + HARM_BITS;
  localparam int PROD_W = SAMPLE_BITS + DIV_BIT + 1;
  localparam int OUT_W  = SAMPLE_BITS + HARM_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                   state_q;
  logic [HARM_BITS-1:0]     n_q;
  logic [HARM_BITS-1:0]     idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [OUT_W-1:0]         sample_q;
  logic                     mult_restart_q;
  logic                     mult_start_q;
  logic                     sine_req_q;
  logic                     sample_valid_q;

  logic signed [PROD_W-1:0] prod_d;
  logic signed [ACC_W-1:0]  acc_d;
  logic [HARM_BITS-1:0]     idx_d;
  logic                     last_d;
  logic [OUT_W-1:0]         sample_d;

  // Datapath: signed sine times zero-extended multiple, running sum, final scaling.
  always_comb begin
    prod_d   = $signed(i_Sine) * $signed({1'b0, i_Mult});
    acc_d    = acc_q + prod_d;
    idx_d    = idx_q + HARM_BITS'(1);
    // A zero multiple means every later harmonic contributes nothing.
    last_d   = (idx_d == n_q) || (i_Mult == '0);
    sample_d = OUT_W'(acc_q >>> DIV_BIT);
  end

  // Sequencer with registered strobes; strobes default low each cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      idx_q          <= '0;
      acc_q          <= '0;
      sample_q       <= '0;
      mult_restart_q <= 1'b0;
      mult_start_q   <= 1'b0;
      sine_req_q     <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      mult_restart_q <= 1'b0;
      mult_start_q   <= 1'b0;
      sine_req_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_Sample_Start) begin
            n_q   <= i_Harmonic_Count;
            acc_q <= '0;
            idx_q <= '0;
            if (i_Harmonic_Count == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q        <= S_RESTART;
              mult_restart_q <= 1'b1;
            end
          end
        end
        S_RESTART: begin
          state_q    <= S_REQ;
          sine_req_q <= 1'b1;
        end
        S_REQ: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_Sine_Valid) begin
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            mult_start_q <= 1'b1;
            if (last_d) begin
              state_q <= S_DONE;
            end else begin
              state_q    <= S_REQ;
              sine_req_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          sample_q       <= sample_d;
          sample_valid_q <= 1'b1;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Mult_Restart = mult_restart_q;
  assign o_Mult_Start   = mult_start_q;
  assign o_Sine_Req     = sine_req_q;
  assign o_Harmonic     = idx_q;
  assign o_Busy         = (state_q != S_IDLE);
  assign o_Sample       = sample_q;
  assign o_Sample_Valid = sample_valid_q;

endmodule

// File: tb/tb_harmonic_accumulator.sv
// Directed bench for harmonic_accumulator: models the attenuation block and
// the sine source, and checks results, timing and control corner cases.
module tb_harmonic_accumulator;

  logic        clk = 1'b0;
  logic        i_Reset;
  logic        i_Sample_Start;
  logic [6:0]  i_Harmonic_Count;
  logic [7:0]  i_Mult;
  logic [15:0] i_Sine;
  logic        i_Sine_Valid;
  logic        o_Mult_Restart;
  logic        o_Mult_Start;
  logic        o_Sine_Req;
  logic [6:0]  o_Harmonic;
  logic        o_Busy;
  logic [22:0] o_Sample;
  logic        o_Sample_Valid;

  int checks = 0;
  int errors = 0;

  int mtab [16];
  int hseq [16];
  int got, vcyc, rcnt, scnt, qcnt, rcyc, busy1, samp;
  logic signed [22:0] samp_s;

  harmonic_accumulator #(.DIV_BIT(8), .SAMPLE_BITS(16), .HARM_BITS(7)) dut (
    .i_Clock          (clk),
    .i_Reset          (i_Reset),
    .i_Sample_Start   (i_Sample_Start),
    .i_Harmonic_Count (i_Harmonic_Count),
    .i_Mult           (i_Mult),
    .i_Sine           (i_Sine),
    .i_Sine_Valid     (i_Sine_Valid),
    .o_Mult_Restart   (o_Mult_Restart),
    .o_Mult_Start     (o_Mult_Start),
    .o_Sine_Req       (o_Sine_Req),
    .o_Harmonic       (o_Harmonic),
    .o_Busy           (o_Busy),
    .o_Sample         (o_Sample),
    .o_Sample_Valid   (o_Sample_Valid)
  );

  always #5 clk = ~clk;

  // Runs one sample starting at the current negedge (cycle 0), acting as the
  // attenuation block and sine source; bs_cyc injects a start while busy.
  task automatic do_sample(input int n, input int lat, input int sine,
                           input int maxc, input int bs_cyc);
    int cnt = 0;
    int mi = 0;
    int cyc = 0;
    got = 0; vcyc = -1; rcnt = 0; scnt = 0; qcnt = 0; rcyc = -1; busy1 = 0; samp = 0;
    i_Harmonic_Count = 7'(n);
    i_Sine           = 16'(sine);
    i_Sample_Start   = 1'b1;
    while (got == 0 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
      i_Sample_Start   = (cyc == bs_cyc);
      i_Harmonic_Count = (cyc == bs_cyc) ? 7'd0 : 7'(n);
      if (cyc == 1) busy1 = int'(o_Busy);
      if (o_Mult_Restart) begin
        rcnt++; rcyc = cyc; mi = 0; i_Mult = 8'(mtab[0]);
      end
      if (o_Mult_Start) begin
        scnt++;
        if (mi < 15) mi++;
        i_Mult = 8'(mtab[mi]);
      end
      i_Sine_Valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) i_Sine_Valid = 1'b1;
      end
      if (o_Sine_Req) begin
        if (qcnt < 16) hseq[qcnt] = int'(o_Harmonic);
        qcnt++;
        cnt = lat;
      end
      if (o_Sample_Valid) begin
        got = 1; vcyc = cyc; samp_s = o_Sample; samp = samp_s;
      end
    end
  endtask

  task automatic set_tab(input int a, input int b, input int c, input int d);
    for (int i = 0; i < 16; i++) mtab[i] = 0;
    mtab[0] = a; mtab[1] = b; mtab[2] = c; mtab[3] = d;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Sample_Start = 1'b0; i_Harmonic_Count = '0;
    i_Mult = '0; i_Sine = '0; i_Sine_Valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_Mult_Restart, o_Mult_Start, o_Sine_Req, o_Busy, o_Sample_Valid} !== 5'b0 ||
        o_Sample !== 23'd0 || o_Harmonic !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got strobes=%b busy=%b sample=%0d harm=%0d, want all 0",
               {o_Mult_Restart, o_Mult_Start, o_Sine_Req, o_Sample_Valid}, o_Busy, o_Sample, o_Harmonic);
    end
    i_Reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    set_tab(255, 0, 0, 0);
    do_sample(1, 1, 1000, 40, -1);
    checks++;
    if (samp !== 996 || vcyc !== 5) begin
      errors++; $display("FAIL single_value: got %0d at cycle %0d, want 996 at cycle 5", samp, vcyc);
    end
    checks++;
    if (rcnt !== 1 || scnt !== 1 || qcnt !== 1) begin
      errors++; $display("FAIL single_pulses: got restart=%0d step=%0d req=%0d, want 1/1/1", rcnt, scnt, qcnt);
    end
    checks++;
    if (rcyc !== 1 || busy1 !== 1) begin
      errors++; $display("FAIL single_restart_cycle: got restart cycle %0d busy %0d, want 1 and 1", rcyc, busy1);
    end
  endtask

  task automatic test_multi(input int bs_cyc);
    set_tab(255, 191, 127, 63);
    do_sample(4, 1, 256, 60, bs_cyc);
    checks++;
    if (samp !== 636 || vcyc !== 11) begin
      errors++; $display("FAIL multi_value(bs=%0d): got %0d at cycle %0d, want 636 at cycle 11", bs_cyc, samp, vcyc);
    end
    checks++;
    if (qcnt !== 4 || rcnt !== 1 || hseq[0] !== 0 || hseq[1] !== 1 || hseq[2] !== 2 || hseq[3] !== 3) begin
      errors++;
      $display("FAIL multi_harmonics: got req=%0d restart=%0d seq=%0d,%0d,%0d,%0d, want 4, 1, 0,1,2,3",
               qcnt, rcnt, hseq[0], hseq[1], hseq[2], hseq[3]);
    end
  endtask

  task automatic test_early_exit();
    set_tab(100, 40, 0, 77);
    do_sample(10, 1, 512, 80, -1);
    checks++;
    if (samp !== 280 || vcyc !== 9) begin
      errors++; $display("FAIL early_value: got %0d at cycle %0d, want 280 at cycle 9", samp, vcyc);
    end
    checks++;
    if (qcnt !== 3 || scnt !== 3) begin
      errors++; $display("FAIL early_requests: got req=%0d step=%0d, want 3/3", qcnt, scnt);
    end
  endtask

  task automatic test_sign();
    set_tab(255, 0, 0, 0);
    do_sample(1, 1, -1000, 40, -1);
    checks++;
    if (samp !== -997 || vcyc !== 5) begin
      errors++; $display("FAIL sign_l1: got %0d at cycle %0d, want -997 at cycle 5", samp, vcyc);
    end
    do_sample(1, 4, -1000, 40, -1);
    checks++;
    if (samp !== -997 || vcyc !== 8) begin
      errors++; $display("FAIL sign_l4: got %0d at cycle %0d, want -997 at cycle 8", samp, vcyc);
    end
  endtask

  task automatic test_zero_n();
    set_tab(255, 0, 0, 0);
    do_sample(0, 1, 1000, 20, -1);
    checks++;
    if (samp !== 0 || vcyc !== 2) begin
      errors++; $display("FAIL zero_n_value: got %0d at cycle %0d, want 0 at cycle 2", samp, vcyc);
    end
    checks++;
    if (rcnt !== 0 || scnt !== 0 || qcnt !== 0) begin
      errors++; $display("FAIL zero_n_pulses: got restart=%0d step=%0d req=%0d, want 0/0/0", rcnt, scnt, qcnt);
    end
  endtask

  task automatic test_back_to_back();
    set_tab(255, 0, 0, 0);
    do_sample(1, 1, 1000, 40, -1);
    do_sample(1, 1, -1000, 40, -1);
    checks++;
    if (samp !== -997 || vcyc !== 5) begin
      errors++; $display("FAIL back_to_back: got %0d at cycle %0d, want -997 at cycle 5", samp, vcyc);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    set_tab(255, 0, 0, 0);
    do_sample(1, 4, 1000, 4, -1);
    i_Reset = 1'b1; i_Sine_Valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_Mult_Restart, o_Mult_Start, o_Sine_Req, o_Busy, o_Sample_Valid} !== 5'b0 ||
        o_Sample !== 23'd0 || o_Harmonic !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b sample=%0d harm=%0d, want all 0", o_Busy, o_Sample, o_Harmonic);
    end
    i_Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_Sample_Valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_mid_no_valid: got %0d valid pulses, want 0", seen);
    end
    do_sample(1, 1, 1000, 40, -1);
    checks++;
    if (samp !== 996 || vcyc !== 5) begin
      errors++; $display("FAIL reset_mid_restart: got %0d at cycle %0d, want 996 at cycle 5", samp, vcyc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi(-1);
    test_early_exit();
    test_sign();
    test_zero_n();
    test_multi(4);
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/harmonic_accumulator.md
# harmonic_accumulator

Sequencer that walks the harmonic series for one output sample, drives the start and restart pulses of the per-harmonic attenuation-multiple block, and consumes that block's multiple. For each harmonic it fetches a signed sine value through a request/valid handshake, multiplies it by the current multiple, and accumulates the result. It emits one scaled sample per request and sits between the sample-rate trigger and the output stage of the additive oscillator.

## Interface

Parameters:
- DIV_BIT, 8: width of the attenuation multiple; also the final right-shift amount.
- SAMPLE_BITS, 16: width of the signed sine input.
- HARM_BITS, 7: width of the harmonic count and index.

Ports:
- i_Clock  in  1  system clock; all logic is on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Sample_Start  in  1  single-cycle pulse that begins one sample computation.
- i_Harmonic_Count  in  HARM_BITS  number of harmonics to sum, N; latched when the start is accepted.
- i_Mult  in  DIV_BIT  current multiple from the attenuation block, unsigned.
- i_Sine  in  SAMPLE_BITS  signed sine value for o_Harmonic.
- i_Sine_Valid  in  1  i_Sine is valid this cycle.
- o_Mult_Restart  out  1  pulse that reloads the initial multiple in the attenuation block.
- o_Mult_Start  out  1  pulse that steps the attenuation block to the next harmonic.
- o_Sine_Req  out  1  single-cycle request for the sine of o_Harmonic.
- o_Harmonic  out  HARM_BITS  harmonic index being processed, 0-based.
- o_Busy  out  1  high in every state except IDLE.
- o_Sample  out  SAMPLE_BITS+HARM_BITS  signed result, registered.
- o_Sample_Valid  out  1  single-cycle pulse when o_Sample updates.

## Operation

- States:
  - IDLE: waits for i_Sample_Start.
  - RESTART: asserts o_Mult_Restart for one cycle.
  - REQ: asserts o_Sine_Req for one cycle.
  - WAIT: waits for i_Sine_Valid.
  - DONE: completes the sample.
- IDLE:
  - On i_Sample_Start, latch N, clear the accumulator and the index.
  - If N == 0, go to DONE. Otherwise go to RESTART.
- RESTART: go to REQ.
- REQ: go to WAIT.
- WAIT, on a cycle with i_Sine_Valid:
  - acc += sext(i_Sine) * zext(i_Mult).
  - Pulse o_Mult_Start.
  - Increment the index.
  - Go to DONE if the index reaches N or if i_Mult == 0 (early exit: all later terms are zero). Otherwise go to REQ.
- DONE:
  - o_Sample <= acc >>> DIV_BIT, an arithmetic shift that floors toward negative infinity.
  - o_Sample_Valid pulses in the following cycle.
  - Return to IDLE.
- Accumulator width is SAMPLE_BITS+DIV_BIT+HARM_BITS, signed, and cannot overflow. Product width is SAMPLE_BITS+DIV_BIT+1, signed.
- o_Harmonic stays stable from REQ through the accumulate cycle.
- i_Sine_Valid outside WAIT is ignored.
- i_Sample_Start while o_Busy is high is ignored. No queueing.
- i_Reset:
  - Forces IDLE.
  - Zeroes the accumulator, index, o_Sample and every output strobe.
  - o_Busy = 0.
  - No o_Mult_Restart is generated by reset itself.
  - Reset mid-operation aborts the sample with no o_Sample_Valid.

## Timing

- Reset values: all outputs 0.
- Cycle numbering: cycle 0 = i_Sample_Start sampled in IDLE.
- Cycle 1: RESTART; o_Mult_Restart high; o_Busy high.
- Cycle 2: REQ. i_Mult carries the initial multiple from this cycle on.
- L = cycles from the o_Sine_Req cycle to i_Sine_Valid, L ≥ 1. Each harmonic takes L+1 cycles.
- Multiple timing: i_Mult updates at the edge after o_Mult_Start. It is sampled only on valid cycles, at least 2 cycles later, so no extra wait state is needed.
- Latency:
  - o_Sample_Valid is high in cycle 3 + K·(L+1), where K = number of harmonics processed (N, or fewer on early exit).
  - N == 0: DONE in cycle 1; o_Sample_Valid in cycle 2 with o_Sample = 0; no restart or step pulses.
- IDLE is re-entered in the o_Sample_Valid cycle. A start in that cycle is accepted.

## Test plan

- N=1, i_Mult=255, L=1, sine +1000 → o_Sample = 996, valid in cycle 5, one o_Mult_Restart, one o_Mult_Start.
- N=4, multiples 255/191/127/63 (initial 255, step 64), sine 256 constant, L=1 → o_Sample = 636 in cycle 11, o_Harmonic sequence 0..3.
- Early exit: N=10, multiples 100/40/0, sine 512, L=1 → three requests only, o_Sample = 280 in cycle 9.
- Sign: N=1, sine -1000, i_Mult=255 → o_Sample = -997. Repeat with L=4 → valid in cycle 8.
- Control edge cases:
  - N=0 → o_Sample = 0 in cycle 2, no mult pulses.
  - Start pulsed while busy → ignored, result unchanged.
  - i_Reset in WAIT → IDLE next cycle, all outputs 0, no o_Sample_Valid; a fresh start afterwards computes correctly.
